// File: rtl/mem_stage_ctrl.sv
// Memory-stage sequencer in front of data_memory: splits 32-bit accesses into two
// 16-bit words, owns the stack pointer and returns load/pop data to the pipeline.
module mem_stage_ctrl #(
    parameter logic [31:0] SP_RESET = 32'h0000_07FF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ReqValid,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        Push,
    input  logic        Pop,
    input  logic        Wide,
    input  logic [31:0] AluAddress,
    input  logic [31:0] StoreData,
    output logic [31:0] Address,
    output logic [15:0] DataIn,
    output logic        MemoryRead,
    output logic        MemoryWrite,
    input  logic [15:0] DataOut,
    output logic        Stall,
    output logic [31:0] LoadData,
    output logic        LoadValid,
    output logic [31:0] SP
);

    localparam int unsigned AddrW = 32;
    localparam int unsigned WordW = 16;
    localparam int unsigned DataW = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_e;

    state_e state;
    state_e nextState;

    logic [WordW-1:0] lowHalf;

    logic doPush;
    logic doPop;
    logic doStore;
    logic doLoad;
    logic reqActive;
    logic isRead;
    logic isWrite;
    logic inSecond;
    logic lastWord;
    logic [AddrW-1:0] spStep;

    // Priority decode Push > Pop > MemWrite > MemRead; reset kills any access in flight.
    assign doPush    = ReqValid && Push;
    assign doPop     = ReqValid && !Push && Pop;
    assign doStore   = ReqValid && !Push && !Pop && MemWrite;
    assign doLoad    = ReqValid && !Push && !Pop && !MemWrite && MemRead;
    assign isRead    = doPop || doLoad;
    assign isWrite   = doPush || doStore;
    assign reqActive = (isRead || isWrite) && !rst;
    assign inSecond  = (state == SECOND);
    assign lastWord  = reqActive && (inSecond || !Wide);
    assign spStep    = Wide ? AddrW'(2) : AddrW'(1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic
    always_comb begin
        nextState = IDLE;
        case (state)
            IDLE: begin
                if (reqActive && Wide) begin
                    nextState = SECOND;
                end
            end
            SECOND: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Memory-side outputs; request inputs are re-read in SECOND since upstream holds them under Stall.
    always_comb begin
        Address     = '0;
        DataIn      = '0;
        MemoryRead  = 1'b0;
        MemoryWrite = 1'b0;
        Stall       = 1'b0;
        if (reqActive) begin
            MemoryRead  = isRead;
            MemoryWrite = isWrite;
            Stall       = Wide && !inSecond;
            if (doPush) begin
                // Wide push stores the high half at SP first so the low half ends up lower in memory.
                Address = inSecond ? (SP - AddrW'(1)) : SP;
                DataIn  = (Wide && !inSecond) ? StoreData[DataW-1:WordW] : StoreData[WordW-1:0];
            end else if (doPop) begin
                Address = inSecond ? (SP + AddrW'(2)) : (SP + AddrW'(1));
            end else begin
                Address = inSecond ? (AluAddress + AddrW'(1)) : AluAddress;
                if (doStore) begin
                    DataIn = inSecond ? StoreData[DataW-1:WordW] : StoreData[WordW-1:0];
                end
            end
        end
    end

    // Stack pointer, read capture and load result
    always_ff @(posedge clk) begin
        if (rst) begin
            SP        <= SP_RESET;
            LoadData  <= '0;
            LoadValid <= 1'b0;
            lowHalf   <= '0;
        end else begin
            LoadValid <= lastWord && isRead;
            if (reqActive && isRead && Wide && !inSecond) begin
                lowHalf <= DataOut;
            end
            if (lastWord && isRead) begin
                LoadData <= Wide ? {DataOut, lowHalf} : {WordW'(0), DataOut};
            end
            if (lastWord && doPush) begin
                SP <= SP - spStep;
            end else if (lastWord && doPop) begin
                SP <= SP + spStep;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with a small combinational-read word memory
// standing in for data_memory.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ReqValid;
    logic        MemRead;
    logic        MemWrite;
    logic        Push;
    logic        Pop;
    logic        Wide;
    logic [31:0] AluAddress;
    logic [31:0] StoreData;
    logic [31:0] Address;
    logic [15:0] DataIn;
    logic        MemoryRead;
    logic        MemoryWrite;
    logic [15:0] DataOut;
    logic        Stall;
    logic [31:0] LoadData;
    logic        LoadValid;
    logic [31:0] SP;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [4096];

    mem_stage_ctrl #(.SP_RESET(32'h0000_07FF)) dut (
        .clk        (clk),
        .rst        (rst),
        .ReqValid   (ReqValid),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Push       (Push),
        .Pop        (Pop),
        .Wide       (Wide),
        .AluAddress (AluAddress),
        .StoreData  (StoreData),
        .Address    (Address),
        .DataIn     (DataIn),
        .MemoryRead (MemoryRead),
        .MemoryWrite(MemoryWrite),
        .DataOut    (DataOut),
        .Stall      (Stall),
        .LoadData   (LoadData),
        .LoadValid  (LoadValid),
        .SP         (SP)
    );

    always #5 clk = ~clk;

    // Memory model: cleared while rst is high, written on the rising edge.
    assign DataOut = mem[Address[11:0]];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 16'h0;
        end else if (MemoryWrite) begin
            mem[Address[11:0]] <= DataIn;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic rd, input logic wr, input logic pu, input logic po,
                       input logic wd, input logic [31:0] a, input logic [31:0] d);
        ReqValid   = 1'b1;
        MemRead    = rd;
        MemWrite   = wr;
        Push       = pu;
        Pop        = po;
        Wide       = wd;
        AluAddress = a;
        StoreData  = d;
    endtask

    task automatic idle();
        ReqValid   = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        Push       = 1'b0;
        Pop        = 1'b0;
        Wide       = 1'b0;
        AluAddress = 32'h0;
        StoreData  = 32'h0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        #1;
        // Request held during reset must not reach memory
        req(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 32'h1111_2222);
        #1;
        chk("rst_mw", 32'(MemoryWrite), 32'h0);
        chk("rst_stall", 32'(Stall), 32'h0);
        chk("rst_addr", Address, 32'h0);
        tick();
        rst = 1'b0;
        idle();
        #1;
        chk("rst_sp", SP, 32'h0000_07FF);
        chk("rst_lv", 32'(LoadValid), 32'h0);
        chk("rst_ld", LoadData, 32'h0);
        chk("idle_addr", Address, 32'h0);

        // Narrow store then narrow load
        req(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1, 32'h0000_FFFF);
        #1;
        chk("ns_mw", 32'(MemoryWrite), 32'h1);
        chk("ns_mr", 32'(MemoryRead), 32'h0);
        chk("ns_addr", Address, 32'h1);
        chk("ns_din", 32'(DataIn), 32'h0000_FFFF);
        chk("ns_stall", 32'(Stall), 32'h0);
        tick();
        req(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1, 32'h0);
        #1;
        chk("nl_mr", 32'(MemoryRead), 32'h1);
        chk("nl_addr", Address, 32'h1);
        chk("nl_stall", 32'(Stall), 32'h0);
        chk("nl_lv0", 32'(LoadValid), 32'h0);
        tick();
        idle();
        #1;
        chk("nl_lv", 32'(LoadValid), 32'h1);
        chk("nl_ld", LoadData, 32'h0000_FFFF);
        tick();
        chk("nl_lv_end", 32'(LoadValid), 32'h0);

        // Wide store then wide load
        req(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8, 32'hDEAD_BEEF);
        #1;
        chk("ws1_stall", 32'(Stall), 32'h1);
        chk("ws1_mw", 32'(MemoryWrite), 32'h1);
        chk("ws1_addr", Address, 32'h8);
        chk("ws1_din", 32'(DataIn), 32'h0000_BEEF);
        tick();
        #1;
        chk("ws2_stall", 32'(Stall), 32'h0);
        chk("ws2_mw", 32'(MemoryWrite), 32'h1);
        chk("ws2_addr", Address, 32'h9);
        chk("ws2_din", 32'(DataIn), 32'h0000_DEAD);
        tick();
        req(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8, 32'h0);
        #1;
        chk("wl1_stall", 32'(Stall), 32'h1);
        chk("wl1_mr", 32'(MemoryRead), 32'h1);
        chk("wl1_addr", Address, 32'h8);
        tick();
        #1;
        chk("wl2_stall", 32'(Stall), 32'h0);
        chk("wl2_addr", Address, 32'h9);
        chk("wl2_lv", 32'(LoadValid), 32'h0);
        tick();
        idle();
        #1;
        chk("wl_lv", 32'(LoadValid), 32'h1);
        chk("wl_ld", LoadData, 32'hDEAD_BEEF);

        // Stack sequence from a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("st_sp0", SP, 32'h0000_07FF);
        req(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h1234_5678);
        #1;
        chk("wpush1_addr", Address, 32'h0000_07FF);
        chk("wpush1_din", 32'(DataIn), 32'h0000_1234);
        chk("wpush1_stall", 32'(Stall), 32'h1);
        tick();
        #1;
        chk("wpush2_addr", Address, 32'h0000_07FE);
        chk("wpush2_din", 32'(DataIn), 32'h0000_5678);
        chk("wpush2_sp", SP, 32'h0000_07FF);
        tick();
        req(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_ABCD);
        #1;
        chk("st_sp1", SP, 32'h0000_07FD);
        chk("npush_addr", Address, 32'h0000_07FD);
        chk("npush_din", 32'(DataIn), 32'h0000_ABCD);
        chk("npush_mw", 32'(MemoryWrite), 32'h1);
        tick();
        req(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        #1;
        chk("st_sp2", SP, 32'h0000_07FC);
        chk("npop_addr", Address, 32'h0000_07FD);
        chk("npop_mr", 32'(MemoryRead), 32'h1);
        tick();
        req(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0);
        #1;
        chk("npop_lv", 32'(LoadValid), 32'h1);
        chk("npop_ld", LoadData, 32'h0000_ABCD);
        chk("st_sp3", SP, 32'h0000_07FD);
        chk("wpop1_addr", Address, 32'h0000_07FE);
        chk("wpop1_stall", 32'(Stall), 32'h1);
        tick();
        #1;
        chk("wpop2_addr", Address, 32'h0000_07FF);
        chk("wpop2_sp", SP, 32'h0000_07FD);
        tick();
        idle();
        #1;
        chk("wpop_lv", 32'(LoadValid), 32'h1);
        chk("wpop_ld", LoadData, 32'h1234_5678);
        chk("st_sp4", SP, 32'h0000_07FF);

        // No-op request
        req(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h55, 32'h0);
        #1;
        chk("nop_mr", 32'(MemoryRead), 32'h0);
        chk("nop_mw", 32'(MemoryWrite), 32'h0);
        chk("nop_addr", Address, 32'h0);
        chk("nop_stall", 32'(Stall), 32'h0);
        tick();

        // Wide load wrapping past the top of the address space
        req(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0);
        #1;
        chk("wrap1_addr", Address, 32'hFFFF_FFFF);
        tick();
        #1;
        chk("wrap2_addr", Address, 32'h0000_0000);
        chk("wrap_nox", 32'($isunknown({Address, DataIn, MemoryRead, MemoryWrite, Stall,
                                        LoadData, LoadValid, SP})), 32'h0);
        tick();
        idle();
        #1;
        chk("wrap_lv", 32'(LoadValid), 32'h1);
        chk("wrap_ld", LoadData, 32'h0);

        // Reset during SECOND of a wide push
        req(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0042);
        tick();
        req(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'hCAFE_F00D);
        #1;
        chk("rsec1_sp", SP, 32'h0000_07FE);
        chk("rsec1_addr", Address, 32'h0000_07FE);
        tick();
        rst = 1'b1;
        #1;
        chk("rsec2_mw", 32'(MemoryWrite), 32'h0);
        chk("rsec2_stall", 32'(Stall), 32'h0);
        tick();
        rst = 1'b0;
        idle();
        #1;
        chk("rsec_sp", SP, 32'h0000_07FF);
        chk("rsec_lv", 32'(LoadValid), 32'h0);
        chk("rsec_mw", 32'(MemoryWrite), 32'h0);
        req(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1, 32'h0000_1234);
        tick();
        req(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1, 32'h0);
        tick();
        idle();
        #1;
        chk("rsec_post_lv", 32'(LoadValid), 32'h1);
        chk("rsec_post_ld", LoadData, 32'h0000_1234);

        // Push and MemWrite together: only the push happens
        req(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0000_5555);
        #1;
        chk("pri_addr", Address, 32'h0000_07FF);
        chk("pri_din", 32'(DataIn), 32'h0000_5555);
        chk("pri_mw", 32'(MemoryWrite), 32'h1);
        tick();
        req(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0);
        #1;
        chk("pri_sp", SP, 32'h0000_07FE);
        tick();
        req(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        #1;
        chk("pri_ld_a", LoadData, 32'h0);
        tick();
        idle();
        #1;
        chk("pri_pop_ld", LoadData, 32'h0000_5555);
        chk("pri_pop_sp", SP, 32'h0000_07FF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-stage sequencer sitting directly upstream of data_memory; it owns the only connection to that block's DataIn/Address/MemoryRead/MemoryWrite/DataOut.
- Accepts one request per cycle from the EX/MEM pipeline register. Request types: plain load/store, stack push/pop, each 16-bit or 32-bit.
- 32-bit accesses are split into two 16-bit word accesses, and the pipeline is stalled for one cycle while this happens.
- Owns the stack pointer register.

Parameters:
- SP_RESET, 32'h0000_07FF, stack pointer value after reset (top word of the data memory).

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ReqValid  in  1  request present this cycle
- MemRead  in  1  load request
- MemWrite  in  1  store request
- Push  in  1  stack push; address comes from SP
- Pop  in  1  stack pop; address comes from SP
- Wide  in  1  1 = 32-bit access, 0 = 16-bit access
- AluAddress  in  32  word address for load/store
- StoreData  in  32  store/push data; [15:0] only when Wide=0
- Address  out  32  to data_memory
- DataIn  out  16  to data_memory
- MemoryRead  out  1  to data_memory
- MemoryWrite  out  1  to data_memory
- DataOut  in  16  from data_memory; combinational read, valid in the same cycle
- Stall  out  1  hold the upstream request and pipeline registers
- LoadData  out  32  load/pop result, zero-extended when narrow
- LoadValid  out  1  one-cycle pulse, LoadData valid
- SP  out  32  current stack pointer

Behaviour:
- Reset:
  - While rst=1: MemoryRead=MemoryWrite=0 (gated combinationally by rst, including mid-operation), Stall=0.
  - After the edge: state IDLE, SP=SP_RESET, LoadData=0, LoadValid=0.
  - Address and DataIn drive 0 whenever no access is active.
- Request decode, priority Push > Pop > MemWrite > MemRead:
  - Lower-priority flags asserted alongside a higher one are ignored.
  - ReqValid=1 with no flag set is a no-op.
- States: IDLE, SECOND.
- IDLE, narrow request: one access this cycle; Stall=0; stay IDLE.
- IDLE, wide request: first word this cycle; Stall=1; go to SECOND.
- SECOND: second word this cycle; Stall=0; return to IDLE.
  - Upstream holds all request inputs stable while Stall=1; the controller re-reads them in SECOND and does not latch them.
- Word mapping, load/store:
  - Narrow: one word at A.
  - Wide: low half at A (first cycle), high half at A+1 (second cycle).
- Push:
  - Narrow: write [15:0] at SP; then SP-=1.
  - Wide: write [31:16] at SP (first cycle), [15:0] at SP-1 (second cycle); then SP-=2.
- Pop:
  - Narrow: read SP+1; then SP+=1.
  - Wide: read SP+1 = low half (first cycle), SP+2 = high half (second cycle); then SP+=2.
- SP update timing: only on the edge ending the final word. Intermediate addresses are computed from the unchanged SP.
- Arithmetic: all address and SP arithmetic is modulo 2^32.
  - A=32'hFFFF_FFFF wide gives second word at 32'h0000_0000.
  - SP=0 narrow push gives SP=32'hFFFF_FFFF.
- Read capture:
  - First-word DataOut is latched into an internal low-half register.
  - On the edge ending the final read word, LoadData is registered; LoadValid=1 for exactly the following cycle.
  - Latency: narrow load 1 cycle, wide load 2 cycles, measured from request acceptance to LoadValid.
- Writes: MemoryWrite is high for exactly one cycle per word. MemoryRead and MemoryWrite are never high together.
- Reset during SECOND: the second word is not issued, SP is not updated, LoadValid is not pulsed.

Test Plan:
- Narrow store 16'hFFFF at A=1, then narrow load A=1 -> one MemoryWrite cycle at Address=1; LoadValid next cycle; LoadData=32'h0000_FFFF; Stall never asserted.
- Wide store 32'hDEAD_BEEF at A=8, then wide load A=8 -> writes BEEF@8 then DEAD@9; Stall=1 for exactly one cycle per request; LoadData=32'hDEAD_BEEF two cycles after the load is accepted.
- After reset, wide push 32'h1234_5678, then narrow push 16'hABCD, then narrow pop, then wide pop -> SP sequence 7FF, 7FD, 7FC, 7FD, 7FF; push writes 1234@7FF, 5678@7FE, ABCD@7FD; pops return 32'h0000_ABCD then 32'h1234_5678.
- Wide load at A=32'hFFFF_FFFF -> second access at Address=32'h0000_0000; no X on any output.
- rst pulsed during SECOND of a wide push -> no second MemoryWrite; SP=32'h7FF after reset; LoadValid=0; next request behaves normally.
- Request with Push and MemWrite both set -> only the push is performed; nothing is written at AluAddress.
